// File: rtl/decoder_1hot_3to8_seq.sv
// 3-to-8 one-hot decoder with a registered valid/ready output stage and a
// free-running sweep mode that walks a single set bit across all 8 positions.
module decoder_1hot_3to8_seq (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [2:0] in_code,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_onehot,
    input  logic       scan,
    input  logic [3:0] dwell,
    output logic       sweep_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FULL = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;

    logic [1:0] state;
    logic [3:0] dwell_cnt;
    logic       xfer_in;
    logic       step_end;
    logic [7:0] code_word;

    // A pending scan request blocks new words so FULL can drain into IDLE first.
    assign in_ready  = !reset && !scan && (state != SCAN) && (!out_valid || out_ready);
    assign xfer_in   = in_valid && in_ready;
    assign step_end  = (dwell_cnt == dwell);
    assign code_word = 8'h01 << in_code;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            sweep_done <= 1'b0;
            dwell_cnt  <= '0;
        end else begin
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan) begin
                        state      <= SCAN;
                        out_valid  <= 1'b1;
                        out_onehot <= 8'h01;
                        dwell_cnt  <= '0;
                    end else if (xfer_in) begin
                        state      <= FULL;
                        out_valid  <= 1'b1;
                        out_onehot <= code_word;
                    end
                end
                FULL: begin
                    if (xfer_in) begin
                        out_onehot <= code_word;
                    end else if (out_ready) begin
                        state      <= IDLE;
                        out_valid  <= 1'b0;
                        out_onehot <= '0;
                    end
                end
                SCAN: begin
                    if (step_end) begin
                        dwell_cnt <= '0;
                        if (out_onehot[7]) begin
                            // Exit is only considered at the end of a full sweep.
                            sweep_done <= 1'b1;
                            if (scan) begin
                                out_onehot <= 8'h01;
                            end else begin
                                state      <= IDLE;
                                out_valid  <= 1'b0;
                                out_onehot <= '0;
                            end
                        end else begin
                            out_onehot <= {out_onehot[6:0], out_onehot[7]};
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 4'd1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    out_valid  <= 1'b0;
                    out_onehot <= '0;
                    dwell_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_1hot_3to8_seq.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a mode/position reference model of the decoder.
module tb_decoder_1hot_3to8_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_onehot;
    logic       scan;
    logic [3:0] dwell;
    logic       sweep_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 = idle, 1 = holding a decoded word, 2 = sweeping.
    int         m_mode;
    int         m_pos;
    int         m_cnt;
    logic [7:0] m_pass;
    bit         m_done;

    always #5 clk = ~clk;

    decoder_1hot_3to8_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_onehot (out_onehot),
        .scan       (scan),
        .dwell      (dwell),
        .sweep_done (sweep_done)
    );

    function automatic logic [7:0] m_word();
        if (m_mode == 1) return m_pass;
        if (m_mode == 2) return 8'(1 << m_pos);
        return 8'h00;
    endfunction

    function automatic bit m_ready();
        return !reset && !scan && (m_mode != 2) && ((m_mode == 0) || out_ready);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && m_ready();
        if (reset) begin
            m_mode = 0; m_cnt = 0; m_done = 0; m_pass = 8'h00; m_pos = 0;
        end else begin
            m_done = 0;
            case (m_mode)
                0: if (scan) begin
                       m_mode = 2; m_pos = 0; m_cnt = 0;
                   end else if (acc) begin
                       m_mode = 1; m_pass = 8'(1 << in_code);
                   end
                1: if (acc) m_pass = 8'(1 << in_code);
                   else if (out_ready) m_mode = 0;
                default: begin
                    if (m_cnt == int'(dwell)) begin
                        m_cnt = 0;
                        if (m_pos == 7) begin
                            m_done = 1;
                            if (scan) m_pos = 0;
                            else m_mode = 0;
                        end else begin
                            m_pos++;
                        end
                    end else begin
                        m_cnt = (m_cnt + 1) % 16;
                    end
                end
            endcase
        end
    endtask

    // Inputs are set before calling; checks land mid-cycle, then one clock edge.
    task automatic tick();
        #1;
        check("in_ready",   32'(in_ready),   32'(m_ready()));
        check("out_valid",  32'(out_valid),  32'(m_mode != 0));
        check("out_onehot", 32'(out_onehot), 32'(m_word()));
        check("sweep_done", 32'(sweep_done), 32'(m_done));
        check("onehot_legal", 32'($countones(out_onehot) <= 1), 32'd1);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_code = 3'd0; out_ready = 1'b0;
        scan = 1'b0; dwell = 4'd0;
        @(posedge clk);
        model_step();
        @(negedge clk);

        // Reset held with in_valid asserted
        repeat (2) begin
            check("rst_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("rst_onehot", 32'(out_onehot), 32'h00);
        end

        // Back-to-back decode
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_code = 3'(i);
            tick();
            check("b2b_word",  32'(out_onehot), 32'(8'h01 << i));
            check("b2b_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // Backpressure on code 5
        in_valid = 1'b1; in_code = 3'd5;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("bp_hold", 32'(out_onehot), 32'h20);
        end
        out_ready = 1'b1;
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Sweep with dwell 0, scan held through a wrap
        scan = 1'b1; dwell = 4'd0;
        tick();
        check("scan_start", 32'(out_onehot), 32'h01);
        repeat (20) tick();

        // Sweep with dwell 2, scan dropped at 8'h08
        reset = 1'b1; tick(); reset = 1'b0;
        dwell = 4'd2;
        for (int i = 0; i < 60 && m_word() != 8'h08; i++) tick();
        check("reach_08", 32'(out_onehot), 32'h08);
        scan = 1'b0;
        repeat (16) tick();
        check("scan_exit", 32'(out_onehot), 32'h00);

        // Reset mid-sweep at 8'h10
        scan = 1'b1; dwell = 4'd1;
        for (int i = 0; i < 60 && m_word() != 8'h10; i++) tick();
        check("reach_10", 32'(out_onehot), 32'h10);
        reset = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_word",  32'(out_onehot), 32'h00);
        check("mid_rst_done",  32'(sweep_done), 32'd0);
        reset = 1'b0; scan = 1'b0;

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = $urandom_range(0, 1);
            in_code   = 3'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 39) == 0) scan = ~scan;
            if ($urandom_range(0, 49) == 0) dwell = 4'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decoder_1hot_3to8_seq.md
DECODER_1HOT_3TO8_SEQ -- requirements
Module: decoder_1hot_3to8_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with all ports as listed below (clock and reset first).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_code is valid this cycle.
REQ-005 in_code  input  3  binary index 0..7 to decode.
REQ-006 in_ready  output  1  block accepts in_code this cycle; combinational.
REQ-007 out_ready  input  1  consumer accepts out_onehot this cycle.
REQ-008 out_valid  output  1  out_onehot holds a valid word; registered.
REQ-009 out_onehot  output  8  one-hot word, bit i set for index i; registered.
REQ-010 scan  input  1  request free-running sweep mode.
REQ-011 dwell  input  4  cycles-per-step minus one in scan mode; sampled every cycle.
REQ-012 sweep_done  output  1  one-cycle pulse when a full sweep completes; registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE (out_valid=0), FULL (out_valid=1, pass mode) and SCAN (out_valid=1, sweep mode).
REQ-014 in_ready SHALL equal !reset && !scan && state!=SCAN && (!out_valid || out_ready).
REQ-015 A transfer-in occurs when in_valid && in_ready; at that edge out_onehot SHALL become 1<<in_code, out_valid SHALL become 1, and state SHALL become FULL (latency one cycle).
REQ-016 In FULL with out_ready=0, out_onehot and out_valid SHALL hold stable.
REQ-017 In FULL with out_ready=1 and a simultaneous transfer-in, the new word SHALL replace the old one with no bubble (one word per cycle sustained).
REQ-018 In FULL with out_ready=1 and no transfer-in, state SHALL become IDLE, out_valid 0, out_onehot 8'h00.
REQ-019 In IDLE, out_onehot SHALL be 8'h00.
REQ-020 In IDLE with scan=1, state SHALL become SCAN, out_onehot 8'h01, dwell counter 0; scan SHALL take priority over in_valid.
REQ-021 scan asserted in FULL SHALL NOT discard the pending word; the block SHALL finish the FULL word, pass through IDLE, then enter SCAN.
REQ-022 In SCAN, a 4-bit dwell counter SHALL increment each cycle; when it equals dwell, it SHALL clear and the step SHALL end.
REQ-023 At step end with out_onehot!=8'h80, out_onehot SHALL rotate left one bit.
REQ-024 At step end with out_onehot=8'h80, sweep_done SHALL pulse high for the following cycle; if scan=1, out_onehot SHALL wrap to 8'h01; if scan=0, state SHALL become IDLE, out_valid 0, out_onehot 8'h00.
REQ-025 Deasserting scan mid-sweep SHALL NOT end SCAN early; exit occurs only at the 8'h80 step end.
REQ-026 In SCAN, out_ready SHALL be ignored and in_ready SHALL be 0.
REQ-027 Each of 8 positions SHALL be held exactly dwell+1 cycles; a sweep SHALL last 8*(dwell+1) cycles.
REQ-028 out_onehot SHALL always be 8'h00 or exactly one bit set.

Reset
REQ-029 With reset=1 at a rising edge, state SHALL become IDLE, out_valid 0, out_onehot 8'h00, sweep_done 0, dwell counter 0, regardless of current state.
REQ-030 in_ready SHALL be 0 in any cycle where reset=1.
REQ-031 Reset SHALL take priority over every other input, including mid-sweep and mid-transfer.

Verification
REQ-032 Reset: hold reset 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_onehot=8'h00 throughout.
REQ-033 Back-to-back: out_ready=1, in_code 0..7 on consecutive cycles -> out_onehot 8'h01,8'h02,...,8'h80 one cycle later each, out_valid continuous.
REQ-034 Backpressure: accept code 5, out_ready=0 for 3 cycles -> out_onehot=8'h20 stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-035 Scan dwell=0, scan held -> 8'h01..8'h80 one per cycle, sweep_done pulse after 8'h80, wrap to 8'h01.
REQ-036 Scan dwell=2, scan dropped while 8'h08 -> each bit held 3 cycles, continues to 8'h80, then IDLE with out_onehot=8'h00.
REQ-037 Reset mid-scan at 8'h10 -> next cycle IDLE, out_valid=0, out_onehot=8'h00, sweep_done=0.
